sprite_overlay: RTL and testbench
=================================

Name: sprite_overlay

Overview:
- Memory-mapped single-sprite pixel stage between the 480p display timing generator and the VGA output pins.
- CPU writes position, size, colour and enable registers over the simple cs/rw byte bus.
- Block latches those registers into shadow copies once per frame and draws a solid rectangle over a fixed background colour.
- Output is registered: it forms the VGA output stage of the design.

Parameters:
- CORDW, 10, screen coordinate width in bits.
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- BG_RGB, 12'h08F, background colour {R,G,B} nibbles.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous reset, active-low.
- cs  in  1  register select.
- rw  in  1  1 = read, 0 = write; sampled when cs=1.
- addr  in  3  register index.
- data_in  in  8  write data.
- data_out  out  8  read data.
- sx  in  CORDW  current pixel x from timing generator.
- sy  in  CORDW  current pixel y from timing generator.
- de  in  1  display enable.
- hsync  in  1  horizontal sync from timing generator.
- vsync  in  1  vertical sync from timing generator.
- vga_hsync  out  1  registered hsync.
- vga_vsync  out  1  registered vsync.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.

Behaviour:
- Register map, pending copy, all 8-bit accesses:
  - 0 X_LO = x[7:0].
  - 1 X_HI = x[9:8] in bits 1:0; other bits read 0.
  - 2 Y_LO = y[7:0].
  - 3 Y_HI = y[9:8].
  - 4 SIZE = width and height in pixels.
  - 5 COLOR_RG = {R[3:0],G[3:0]}.
  - 6 CTRL = {enable, 3'b0, B[3:0]}.
  - 7 FRAME = read-only frame counter; writes ignored.
- Reset values: x=0, y=0, size=32, R=F, G=8, B=0, enable=1, frame=0. Shadow copies take the same values.
- Outputs on reset: data_out=0, vga_hsync=0, vga_vsync=0, vga_r/g/b=0.
- Reset asserted mid-frame clears every register immediately, independent of clk.
- Write: on a clk edge with cs=1 and rw=0, the pending register at addr takes data_in.
- Read: on a clk edge with cs=1 and rw=1, data_out takes the pending register value (or FRAME) at addr. Latency is 1 cycle. data_out holds its value otherwise.
- Frame boundary is the cycle with sx==0 and sy==V_RES. On that edge:
  - all shadow registers take the pending values;
  - FRAME increments modulo 256 (255 -> 0).
- A write on the boundary cycle updates pending only. The shadow still takes the old pending value, so the new value takes effect at the next boundary.
- Hit test, combinational on shadow values. Use CORDW+1-bit sums so there is no wrap:
  - hit = enable && size!=0 && sx>=x && sx<x+size && sy>=y && sy<y+size.
  - Sprites extending past H_RES/V_RES are clipped, because de=0 there. They never wrap to column or row 0.
- Output stage: one register stage, 1-cycle latency from sx/sy/de/hsync/vsync to outputs.
  - vga_hsync and vga_vsync are delayed copies of hsync and vsync.
  - If de=0, RGB = 0.
  - Else if hit, RGB = shadow colour.
  - Else RGB = BG_RGB.
- There is no FSM beyond pending/shadow/frame. Bus access and pixel path are fully concurrent.

Test Plan:
1. Release reset; feed sx=0,sy=0,de=1, then sx=32,sy=0,de=1, then de=0 -> next cycles show RGB=F,8,0, then 0,8,F, then 0,0,0. Syncs track the inputs with 1-cycle delay.
2. Mid-frame at sy=100, write X_LO=100, X_HI=0 -> pixel (100,200) stays background in this frame. After the boundary (sx=0,sy=480), pixel (100,0) is F,8,0 and pixel (99,0) is 0,8,F.
3. Write X_LO=0x76, X_HI=2 (x=630), SIZE=32, let a boundary pass -> pixels 630..639 of rows 0..31 are sprite colour; pixel (0,0) is background.
4. Write CTRL=0x03 on the exact boundary cycle -> the sprite is still drawn this frame. After the next boundary it is disabled: all active pixels are 0,8,F.
5. Run 257 boundaries, read FRAME -> data_out=0x01 one cycle after the read. Read X_HI after writing 0xFF -> 0x03. Write to addr 7 has no effect.
6. Assert reset mid-line with non-default registers -> outputs go 0 immediately. After release, the defaults of scenario 1 reappear and FRAME reads 0.

Source files
------------

// File: rtl/sprite_overlay_if.sv
// Byte-wide register bus for the sprite overlay.
// The CPU side drives cs/rw/addr/data_in; the overlay returns data_out.
interface sprite_overlay_if;
    logic       cs;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output cs, rw, addr, data_in,
        input  data_out
    );

    modport slave (
        input  cs, rw, addr, data_in,
        output data_out
    );
endinterface

// File: rtl/sprite_overlay.sv
// Single solid-rectangle sprite drawn over a flat background.
// CPU-visible pending registers are copied to shadows once per frame.
module sprite_overlay #(
    parameter int          CORDW  = 10,
    parameter int          H_RES  = 640,
    parameter int          V_RES  = 480,
    parameter logic [11:0] BG_RGB = 12'h08F
) (
    input  logic             clk,
    input  logic             reset,
    sprite_overlay_if.slave  bus,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
        logic [7:0]       size;
        logic [3:0]       r;
        logic [3:0]       g;
        logic [3:0]       b;
        logic             en;
    } sprite_t;

    localparam sprite_t SPR_RST = '{
        x: '0, y: '0, size: 8'd32,
        r: 4'hF, g: 4'h8, b: 4'h0, en: 1'b1
    };

    localparam logic [CORDW:0] HMAX = (CORDW+1)'(H_RES);
    localparam logic [CORDW:0] VMAX = (CORDW+1)'(V_RES);

    sprite_t    pend;
    sprite_t    shad;
    logic [7:0] frame;
    logic [7:0] rd_val;
    logic       boundary;
    logic       wr_en;
    logic       rd_en;

    assign boundary = (sx == '0) && (sy == CORDW'(V_RES));
    assign wr_en    = bus.cs && !bus.rw;
    assign rd_en    = bus.cs && bus.rw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= SPR_RST;
        end else if (wr_en) begin
            case (bus.addr)
                3'd0: pend.x[7:0] <= bus.data_in;
                3'd1: pend.x[CORDW-1:8] <= bus.data_in[CORDW-9:0];
                3'd2: pend.y[7:0] <= bus.data_in;
                3'd3: pend.y[CORDW-1:8] <= bus.data_in[CORDW-9:0];
                3'd4: pend.size <= bus.data_in;
                3'd5: {pend.r, pend.g} <= bus.data_in;
                3'd6: begin
                    pend.en <= bus.data_in[7];
                    pend.b  <= bus.data_in[3:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (bus.addr)
            3'd0: rd_val = pend.x[7:0];
            3'd1: rd_val[CORDW-9:0] = pend.x[CORDW-1:8];
            3'd2: rd_val = pend.y[7:0];
            3'd3: rd_val[CORDW-9:0] = pend.y[CORDW-1:8];
            3'd4: rd_val = pend.size;
            3'd5: rd_val = {pend.r, pend.g};
            3'd6: rd_val = {pend.en, 3'b000, pend.b};
            default: rd_val = frame;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.data_out <= 8'h00;
        end else if (rd_en) begin
            bus.data_out <= rd_val;
        end
    end

    // A write landing on the boundary edge misses this copy by design.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shad  <= SPR_RST;
            frame <= 8'h00;
        end else if (boundary) begin
            shad  <= pend;
            frame <= frame + 8'd1;
        end
    end

    logic [CORDW:0] px, py;
    logic [CORDW:0] x0, y0, x1, y1;
    logic           hit;

    always_comb begin
        px  = {1'b0, sx};
        py  = {1'b0, sy};
        x0  = {1'b0, shad.x};
        y0  = {1'b0, shad.y};
        x1  = x0 + {{(CORDW-7){1'b0}}, shad.size};
        y1  = y0 + {{(CORDW-7){1'b0}}, shad.size};
        hit = shad.en && (shad.size != 8'd0)
            && (px >= x0) && (px < x1)
            && (py >= y0) && (py < y1)
            && (px < HMAX) && (py < VMAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_r     <= 4'h0;
            vga_g     <= 4'h0;
            vga_b     <= 4'h0;
        end else begin
            vga_hsync <= hsync;
            vga_vsync <= vsync;
            if (!de) begin
                {vga_r, vga_g, vga_b} <= 12'h000;
            end else if (hit) begin
                {vga_r, vga_g, vga_b} <= {shad.r, shad.g, shad.b};
            end else begin
                {vga_r, vga_g, vga_b} <= BG_RGB;
            end
        end
    end

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: pixel vectors, register bus,
// frame-boundary latching and asynchronous reset.
module tb_sprite_overlay;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync;
    logic       vga_hsync, vga_vsync;
    logic [3:0] vga_r, vga_g, vga_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sprite_overlay_if bus ();

    sprite_overlay dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sx        (sx),
        .sy        (sy),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b)
    );

    localparam logic [11:0] SPR = 12'hF80;
    localparam logic [11:0] BG  = 12'h08F;
    localparam logic [11:0] OFF = 12'h000;

    typedef struct {
        int          x;
        int          y;
        logic        d;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_rgb(input string name, input logic [11:0] exp);
        check(name, {4'h0, vga_r, vga_g, vga_b}, {4'h0, exp});
    endtask

    task automatic idle();
        sx = 10'd5; sy = 10'd0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input logic d,
                       input logic hs, input logic vs);
        sx = 10'(x); sy = 10'(y); de = d; hsync = hs; vsync = vs;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.data_in = d;
        @(posedge clk); #1;
        bus.cs = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = a;
        @(posedge clk); #1;
        bus.cs = 1'b0;
        d = bus.data_out;
    endtask

    task automatic frame_edge();
        sx = 10'd0; sy = 10'd480; de = 1'b0;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 5; i++) begin
            pix(tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].hs, tbl[i].vs);
            check_rgb($sformatf("%s_rgb%0d", tag, i), tbl[i].rgb);
            check($sformatf("%s_sync%0d", tag, i),
                  {14'h0, vga_hsync, vga_vsync},
                  {14'h0, tbl[i].hs, tbl[i].vs});
        end
    endtask

    initial begin
        logic [7:0] d;

        tbl[0] = '{x: 0,  y: 0,  d: 1'b1, hs: 1'b1, vs: 1'b0, rgb: SPR};
        tbl[1] = '{x: 32, y: 0,  d: 1'b1, hs: 1'b0, vs: 1'b1, rgb: BG};
        tbl[2] = '{x: 31, y: 31, d: 1'b1, hs: 1'b0, vs: 1'b0, rgb: SPR};
        tbl[3] = '{x: 0,  y: 32, d: 1'b1, hs: 1'b1, vs: 1'b1, rgb: BG};
        tbl[4] = '{x: 10, y: 10, d: 1'b0, hs: 1'b1, vs: 1'b1, rgb: OFF};

        bus.cs = 1'b0; bus.rw = 1'b1; bus.addr = 3'd0; bus.data_in = 8'h00;
        sx = 10'd0; sy = 10'd0; de = 1'b1; hsync = 1'b1; vsync = 1'b1;

        // Reset held: outputs stay zero despite active inputs.
        repeat (2) @(posedge clk);
        #1;
        check_rgb("rst_rgb", OFF);
        check("rst_sync", {14'h0, vga_hsync, vga_vsync}, 16'h0);
        check("rst_dout", {8'h0, bus.data_out}, 16'h0);
        reset = 1'b1;
        idle();
        @(posedge clk); #1;

        run_table("s1");
        rd(3'd4, d); check("rd_size_rst", {8'h0, d}, 16'h0020);
        rd(3'd6, d); check("rd_ctrl_rst", {8'h0, d}, 16'h0080);
        rd(3'd5, d); check("rd_rg_rst", {8'h0, d}, 16'h00F8);

        // Pending x change invisible until the boundary.
        pix(0, 100, 1'b1, 1'b0, 1'b0);
        wr(3'd0, 8'd100);
        wr(3'd1, 8'd0);
        pix(10, 10, 1'b1, 1'b0, 1'b0);   check_rgb("s2_old_sprite", SPR);
        pix(100, 200, 1'b1, 1'b0, 1'b0); check_rgb("s2_100_200", BG);
        frame_edge();
        pix(100, 0, 1'b1, 1'b0, 1'b0);   check_rgb("s2_100_0", SPR);
        pix(99, 0, 1'b1, 1'b0, 1'b0);    check_rgb("s2_99_0", BG);
        pix(131, 31, 1'b1, 1'b0, 1'b0);  check_rgb("s2_131_31", SPR);
        pix(132, 0, 1'b1, 1'b0, 1'b0);   check_rgb("s2_132_0", BG);

        // Right-edge clipping, no wrap to column 0.
        wr(3'd0, 8'h76);
        wr(3'd1, 8'h02);
        wr(3'd4, 8'd32);
        frame_edge();
        pix(630, 0, 1'b1, 1'b0, 1'b0);   check_rgb("s3_630_0", SPR);
        pix(639, 31, 1'b1, 1'b0, 1'b0);  check_rgb("s3_639_31", SPR);
        pix(629, 0, 1'b1, 1'b0, 1'b0);   check_rgb("s3_629_0", BG);
        pix(639, 32, 1'b1, 1'b0, 1'b0);  check_rgb("s3_639_32", BG);
        pix(0, 0, 1'b1, 1'b0, 1'b0);     check_rgb("s3_0_0", BG);
        pix(5, 5, 1'b1, 1'b0, 1'b0);     check_rgb("s3_5_5", BG);
        pix(639, 0, 1'b0, 1'b0, 1'b0);   check_rgb("s3_de0", OFF);

        // CTRL written on the boundary cycle lands one frame late.
        wr(3'd0, 8'd0);
        wr(3'd1, 8'd0);
        sx = 10'd0; sy = 10'd480; de = 1'b0;
        bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = 3'd6; bus.data_in = 8'h03;
        @(posedge clk); #1;
        bus.cs = 1'b0;
        pix(0, 0, 1'b1, 1'b0, 1'b0);     check_rgb("s4_still_on", SPR);
        pix(31, 31, 1'b1, 1'b0, 1'b0);   check_rgb("s4_still_on2", SPR);
        frame_edge();
        pix(0, 0, 1'b1, 1'b0, 1'b0);     check_rgb("s4_off_0_0", BG);
        pix(20, 20, 1'b1, 1'b0, 1'b0);   check_rgb("s4_off_20_20", BG);
        rd(3'd6, d); check("s4_rd_ctrl", {8'h0, d}, 16'h0003);

        // Non-default colour, then asynchronous reset mid-line.
        wr(3'd5, 8'h12);
        wr(3'd6, 8'h8C);
        frame_edge();
        pix(0, 0, 1'b1, 1'b1, 1'b1);     check_rgb("s6_custom", 12'h12C);
        check("s6_sync_pre", {14'h0, vga_hsync, vga_vsync}, 16'h0003);
        #2 reset = 1'b0;
        #1;
        check_rgb("s6_async_rgb", OFF);
        check("s6_async_sync", {14'h0, vga_hsync, vga_vsync}, 16'h0);
        check("s6_async_dout", {8'h0, bus.data_out}, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(posedge clk); #1;
        run_table("s6");
        rd(3'd7, d); check("s6_frame0", {8'h0, d}, 16'h0000);
        rd(3'd5, d); check("s6_rg_dflt", {8'h0, d}, 16'h00F8);

        // Frame counter wraps modulo 256; bus read details.
        for (int i = 0; i < 257; i++) frame_edge();
        rd(3'd7, d); check("s5_frame257", {8'h0, d}, 16'h0001);
        @(posedge clk); #1;
        check("s5_dout_hold", {8'h0, bus.data_out}, 16'h0001);
        wr(3'd1, 8'hFF);
        check("s5_dout_hold_wr", {8'h0, bus.data_out}, 16'h0001);
        rd(3'd1, d); check("s5_xhi", {8'h0, d}, 16'h0003);
        wr(3'd7, 8'h55);
        rd(3'd7, d); check("s5_frame_ro", {8'h0, d}, 16'h0001);
        rd(3'd3, d); check("s5_yhi", {8'h0, d}, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
